// File: rtl/mcp3202_spi_responder.sv
// MCP3202 12-bit ADC emulator: SPI mode 0,0 responder with cs/sck/mosi synchronizers.
// Define MCP3202_LSBF_EN to append the LSB-first tail (B1..B11) when msbf=0.
module mcp3202_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] ch0_sample,
  input  logic [11:0] ch1_sample,
  output logic [2:0]  cfg,
  output logic        sample_latch,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT_START, ST_SGL, ST_ODD, ST_MSBF,
    ST_NULL, ST_DATA, ST_LSB, ST_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic        sck_d;
  logic        sck_s, cs_n_s, mosi_s, sck_rise, sck_fall;
  logic [1:0]  cmd, cmd_nxt;      // {sgl, odd} gathered during the command phase
  logic [2:0]  cfg_nxt;
  logic [3:0]  bit_cnt, cnt_nxt;
  logic [11:0] word;
  logic        miso_nxt, oe_nxt, latch_nxt, done_nxt, err_nxt;

  // Pin synchronizers: cs idles deasserted, so its chain resets to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_n_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    cfg_nxt   = cfg;
    cnt_nxt   = bit_cnt;
    miso_nxt  = miso;
    oe_nxt    = miso_oe;
    latch_nxt = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    // cs deassertion has priority over any coincident sck edge
    if (cs_n_s) begin
      state_nxt = ST_IDLE;
      miso_nxt  = 1'b0;
      oe_nxt    = 1'b0;
      err_nxt   = (state inside {ST_SGL, ST_ODD, ST_MSBF, ST_NULL, ST_DATA, ST_LSB});
    end else begin
      case (state)
        ST_IDLE:       state_nxt = ST_WAIT_START;
        ST_WAIT_START: if (sck_rise && mosi_s) state_nxt = ST_SGL;
        ST_SGL: if (sck_rise) begin
          cmd_nxt[1] = mosi_s;
          state_nxt  = ST_ODD;
        end
        ST_ODD: if (sck_rise) begin
          cmd_nxt[0] = mosi_s;
          state_nxt  = ST_MSBF;
        end
        ST_MSBF: if (sck_rise) begin
          cfg_nxt   = {cmd, mosi_s};
          state_nxt = ST_NULL;
        end
        ST_NULL: if (sck_fall) begin
          latch_nxt = 1'b1;
          oe_nxt    = 1'b1;
          miso_nxt  = 1'b0;
          cnt_nxt   = 4'd0;
          state_nxt = ST_DATA;
        end
        ST_DATA: if (sck_fall) begin
          miso_nxt = word[4'd11 - bit_cnt];
          cnt_nxt  = bit_cnt + 4'd1;
          if (bit_cnt == 4'd11) begin
`ifdef MCP3202_LSBF_EN
            if (!cfg[0]) begin
              // B0 is shared; the LSB-first tail starts at B1
              state_nxt = ST_LSB;
              cnt_nxt   = 4'd1;
            end else begin
              state_nxt = ST_HOLD;
              done_nxt  = 1'b1;
            end
`else
            state_nxt = ST_HOLD;
            done_nxt  = 1'b1;
`endif
          end
        end
        ST_LSB: if (sck_fall) begin
          miso_nxt = word[bit_cnt];
          cnt_nxt  = bit_cnt + 4'd1;
          if (bit_cnt == 4'd11) begin
            state_nxt = ST_HOLD;
            done_nxt  = 1'b1;
          end
        end
        ST_HOLD: if (sck_fall) miso_nxt = 1'b0;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cmd          <= 2'b00;
      cfg          <= 3'b000;
      bit_cnt      <= 4'd0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      sample_latch <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cmd          <= cmd_nxt;
      cfg          <= cfg_nxt;
      bit_cnt      <= cnt_nxt;
      miso         <= miso_nxt;
      miso_oe      <= oe_nxt;
      sample_latch <= latch_nxt;
      frame_done   <= done_nxt;
      frame_err    <= err_nxt;
    end
  end

  // Channel word is data only; it is always written before DATA reads it
  always_ff @(posedge clk) begin
    if (latch_nxt) word <= cmd[0] ? ch1_sample : ch0_sample;
  end

endmodule

// File: doc/mcp3202_spi_responder.md
# mcp3202_spi_responder

- Synthesizable SPI responder that emulates an MCP3202 12-bit ADC on the FPGA fabric, for hardware-in-the-loop checking of the MCP3202 SPI master and the downstream ECG filter chain without the real chip.
- Decodes the start, SGL/DIFF, ODD/SIGN and MSBF command bits from the master.
- Latches a 12-bit word from one of two user-supplied channel inputs and shifts it out on MISO with MCP3202 bit ordering.
- Samples the external SPI pins, asynchronous to `clk`, through synchronizers.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the sck/cs/mosi synchronizers; legal range 2-3.

Ports:
- `clk`  in  1  system clock, 10-200 MHz, at least 16x the SCK frequency.
- `rst_n`  in  1  asynchronous active-low reset.
- `sck`  in  1  SPI clock from the master, mode 0,0, idle low.
- `cs`  in  1  chip select from the master, active low.
- `mosi`  in  1  command bits from the master.
- `miso`  out  1  data to the master; 0 whenever `miso_oe`=0.
- `miso_oe`  out  1  tri-state enable for the MISO pad.
- `ch0_sample`  in  12  value returned for channel 0.
- `ch1_sample`  in  12  value returned for channel 1.
- `cfg`  out  3  {sgl, odd, msbf} of the last decoded command.
- `sample_latch`  out  1  1-clk pulse when the channel word is captured.
- `frame_done`  out  1  1-clk pulse when all data bits have been shifted out.
- `frame_err`  out  1  1-clk pulse when cs deasserts mid-frame.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Edge detection uses the synchronized signals: `sck_rise`/`sck_fall` compare the last synchronizer stage with one extra delay flop. `cs_n_s` is the synchronized cs.
- IDLE: waits for `cs_n_s`=0, then goes to WAIT_START.
- WAIT_START: on `sck_rise` with mosi=1, goes to SGL. Leading zeros are ignored.
- SGL, ODD, MSBF: on each `sck_rise`, capture mosi into the internal command register and advance. On leaving MSBF, `cfg` is updated.
- NULL: on the next `sck_fall`:
  - latch the selected channel, `odd`=0 selecting ch0 and `odd`=1 selecting ch1; DIFF mode uses the same mapping.
  - pulse `sample_latch`.
  - set `miso_oe`=1 and `miso`=0 (null bit).
- DATA: on each subsequent `sck_fall`, drive B11 down to B0 from the latched word. The 4-bit bit counter is reset on entry.
- After B0:
  - msbf=1: go to HOLD.
  - msbf=0: behaviour depends on the macro (see Configuration).
- Entering HOLD pulses `frame_done`. In HOLD, `miso`=0 is driven on each `sck_fall` while cs stays low.
- cs deasserted (`cs_n_s`=1) in any state:
  - go to IDLE next clk and set `miso_oe`=0, `miso`=0.
  - pulse `frame_err` if the state was SGL, ODD, MSBF, NULL, DATA or LSB.
- Channel inputs are sampled only at the NULL edge; later changes do not affect the frame in progress.
- Simultaneous cs deassert and an SCK edge in the same clk: cs wins and the edge is ignored.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `cfg`=3'b000, `sample_latch`=0, `frame_done`=0, `frame_err`=0, `busy`=0, state IDLE, synchronizers 1 for cs and 0 for sck/mosi.
- Pin to action latency is `SYNC_STAGES`+1 clk. MISO changes `SYNC_STAGES`+1 clk after the physical falling SCK edge, which is 30 ns at 100 MHz and well inside the 200 ns tEN of the datasheet.
- `miso_oe` rises in the same clk as the null bit and falls `SYNC_STAGES`+1 clk after cs rises.
- All pulses are exactly one clk wide.
- Reset mid-frame returns to IDLE immediately, with no pulses asserted.

## Configuration
- `MCP3202_LSBF_EN` defined, and msbf=0:
  - after B0, go to LSB state and drive B1..B11 on the next 11 `sck_fall`; B0 is shared, per the datasheet.
  - then go to HOLD and pulse `frame_done` on entry.
- Undefined: msbf=0 is handled as msbf=1, i.e. HOLD immediately after B0. `cfg[0]` still reports the received bit.

## Test plan
- Master frame, ch0=12'h75F, command 1,1,0,1 (start, sgl, odd, msbf), 900 kHz SCK, 100 MHz clk -> `cfg`=3'b101, master receives null 0 then 0x75F, single `frame_done` pulse, `frame_err`=0.
- Command odd=1, ch1=12'h4E8, ch0=12'h000, with ch1 changed to 12'hFFF after `sample_latch` -> MISO still returns 0x4E8.
- Three leading zero bits before the start bit, ch0=12'h01A -> frame decodes normally, MISO returns 0x01A.
- cs raised after the 5th data bit -> `frame_err` pulse, `miso_oe`=0 within 3 clk, next frame decodes cleanly.
- With `MCP3202_LSBF_EN`, msbf=0, ch0=12'hA53 -> 23 data bits: 0xA53 MSB-first then bits 1..11 LSB-first. Without the macro, only 0xA53 is sent, followed by zeros.
- `rst_n` pulsed low during the DATA state -> all outputs take their reset values asynchronously, and the next frame is correct.
